// File: rtl/uart_rx_link_if.sv
// Receive-side handshake bundle: byte, status flags, valid/ready and the overrun clear.
interface uart_rx_link_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready, err_clr
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready, err_clr
    );
endinterface

// File: rtl/uart_rx_link.sv
// 16x-oversampled 8-bit UART receiver with optional parity, error flags and a
// one-entry valid/ready output register with a sticky overrun flag.
module uart_rx_link #(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int PARITY       = 0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rx_in,
    uart_rx_link_if.master rx_bus
);

    localparam int SAMPLE_DIV = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV_W      = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DELIVER
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             stop_q, stop_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic             par_xor;
    logic             par_fail;

    // Next-state logic: synchronizer, tick divider, frame FSM and output register
    always_comb begin
        rx_meta_d    = rx_in;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_d        = par_q;
        stop_d       = stop_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;

        tick   = (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + 1'b1;
        scnt_d = tick ? scnt_q + 4'd1 : scnt_q;

        par_xor = (^shift_q) ^ par_q;
        if (PARITY == 1) begin
            par_fail = ~par_xor;
        end else if (PARITY == 2) begin
            par_fail = par_xor;
        end else begin
            par_fail = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    scnt_d  = '0;
                    div_d   = '0;
                end
            end
            S_START: begin
                if (tick && scnt_q == 4'd7) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        scnt_d    = '0;
                        bit_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick && scnt_q == 4'd15) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick && scnt_q == 4'd15) begin
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && scnt_q == 4'd15) begin
                    stop_d  = rx_s_q;
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rx_bus.err_clr) begin
            overrun_d = 1'b0;
        end

        if (state_q == S_DELIVER) begin
            if (!rx_valid_q || rx_bus.rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = par_fail;
                frame_err_d  = ~stop_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; the synchronizer idles high like the line
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            div_q        <= '0;
            scnt_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            stop_q       <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            div_q        <= div_d;
            scnt_q       <= scnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            stop_q       <= stop_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_bus.rx_data    = rx_data_q;
    assign rx_bus.rx_valid   = rx_valid_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_link.sv
// Bench for uart_rx_link: one instance without parity, one with even parity,
// each on its own serial line, with a scoreboard per instance.
module tb_uart_rx_link;

    localparam int BIT_CYC = 160;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic line_a = 1'b1;
    logic line_b = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    uart_rx_link_if bus0 ();
    uart_rx_link_if bus2 ();

    uart_rx_link #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .PARITY(0)) dut0 (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rx_in  (line_a),
        .rx_bus (bus0)
    );

    uart_rx_link #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .PARITY(2)) dut2 (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rx_in  (line_b),
        .rx_bus (bus2)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        bit         chk_lat;
        int         start_cyc;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [7:0] data;
        bit         par;
        bit         stop;
        int         gap;
        logic [7:0] e_data;
        bit         e_perr;
        bit         e_ferr;
        bit         chk_lat;
    } vec_t;

    exp_t q0[$];
    exp_t q2[$];
    vec_t tbl[8];

    // Free-running clock and cycle counter
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Abort guard so the run can never hang
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic scoreItem(input string tag, input logic [7:0] d, input logic pe, input logic fe, input exp_t e);
        int lat;
        checkOutput({tag, "_data"}, 32'(d), 32'(e.data));
        checkOutput({tag, "_parity_err"}, 32'(pe), 32'(e.perr));
        checkOutput({tag, "_frame_err"}, 32'(fe), 32'(e.ferr));
        if (e.chk_lat) begin
            lat = cyc - e.start_cyc;
            checks++;
            if (lat < 1523 || lat > 1543) begin
                failures++;
                $display("[TB] FAIL %s_latency actual=%0d required=1523..1543", tag, lat);
            end
        end
    endtask

    task automatic driveLine(input bit sel, input logic v);
        if (sel) line_b = v;
        else     line_a = v;
    endtask

    // Sends one frame on the selected line; sel=1 frames carry a parity bit
    task automatic applyStimulus(input vec_t v, input bit push);
        exp_t e;
        e.data      = v.e_data;
        e.perr      = v.e_perr;
        e.ferr      = v.e_ferr;
        e.chk_lat   = v.chk_lat;
        e.start_cyc = cyc;
        if (push) begin
            if (v.sel) q2.push_back(e);
            else       q0.push_back(e);
        end
        driveLine(v.sel, 1'b0);
        repeat (BIT_CYC) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            driveLine(v.sel, v.data[i]);
            repeat (BIT_CYC) @(negedge clk_in);
        end
        if (v.sel) begin
            driveLine(v.sel, v.par);
            repeat (BIT_CYC) @(negedge clk_in);
        end
        driveLine(v.sel, v.stop);
        repeat (BIT_CYC) @(negedge clk_in);
        driveLine(v.sel, 1'b1);
        repeat (v.gap) @(negedge clk_in);
    endtask

    // Scoreboard: every accepted byte must match the oldest expectation
    always begin
        @(negedge clk_in);
        #1;
        if (bus0.rx_valid && bus0.rx_ready) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL d0_unexpected actual=0x%0h required=no byte", bus0.rx_data);
            end else begin
                scoreItem("d0", bus0.rx_data, bus0.parity_err, bus0.frame_err, q0.pop_front());
            end
        end
        if (bus2.rx_valid && bus2.rx_ready) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL d2_unexpected actual=0x%0h required=no byte", bus2.rx_data);
            end else begin
                scoreItem("d2", bus2.rx_data, bus2.parity_err, bus2.frame_err, q2.pop_front());
            end
        end
    end

    // Main sequence
    initial begin
        vec_t v;
        exp_t e;
        int   waited;

        //          sel  data   par  stop gap  e_data e_perr e_ferr lat
        tbl[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 40, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'h55, 1'b0, 1'b0, 40, 8'h55, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h01, 1'b0, 1'b1, 40, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h07, 1'b1, 1'b1, 40, 8'h07, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h07, 1'b0, 1'b1, 40, 8'h07, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 40, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 8'hFF, 1'b0, 1'b1, 40, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'h80, 1'b0, 1'b0, 40, 8'h80, 1'b1, 1'b1, 1'b0};

        bus0.rx_ready = 1'b1;
        bus0.err_clr  = 1'b0;
        bus2.rx_ready = 1'b1;
        bus2.err_clr  = 1'b0;
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        #1;
        checkOutput("rst_d0_data", 32'(bus0.rx_data), 32'h0);
        checkOutput("rst_d0_valid", 32'(bus0.rx_valid), 32'h0);
        checkOutput("rst_d0_perr", 32'(bus0.parity_err), 32'h0);
        checkOutput("rst_d0_ferr", 32'(bus0.frame_err), 32'h0);
        checkOutput("rst_d0_overrun", 32'(bus0.overrun), 32'h0);
        checkOutput("rst_d2_valid", 32'(bus2.rx_valid), 32'h0);
        checkOutput("rst_d2_overrun", 32'(bus2.overrun), 32'h0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i], 1'b1);
        end

        // Two back-to-back frames with the consumer stalled: second byte is dropped
        bus0.rx_ready = 1'b0;
        v = '{1'b0, 8'h3C, 1'b0, 1'b1, 0, 8'h3C, 1'b0, 1'b0, 1'b0};
        applyStimulus(v, 1'b1);
        v = '{1'b0, 8'hC3, 1'b0, 1'b1, 40, 8'hC3, 1'b0, 1'b0, 1'b0};
        applyStimulus(v, 1'b0);
        #1;
        checkOutput("ovr_valid_held", 32'(bus0.rx_valid), 32'h1);
        checkOutput("ovr_data_held", 32'(bus0.rx_data), 32'h3C);
        checkOutput("ovr_flag_set", 32'(bus0.overrun), 32'h1);
        @(negedge clk_in);
        bus0.rx_ready = 1'b1;
        @(negedge clk_in);
        bus0.rx_ready = 1'b0;
        #1;
        checkOutput("ovr_valid_cleared", 32'(bus0.rx_valid), 32'h0);
        checkOutput("ovr_data_kept", 32'(bus0.rx_data), 32'h3C);
        checkOutput("ovr_flag_sticky", 32'(bus0.overrun), 32'h1);
        @(negedge clk_in);
        bus0.err_clr = 1'b1;
        @(negedge clk_in);
        bus0.err_clr = 1'b0;
        #1;
        checkOutput("ovr_flag_cleared", 32'(bus0.overrun), 32'h0);
        bus0.rx_ready = 1'b1;
        repeat (10) @(negedge clk_in);

        // Short low glitch must be rejected at the mid-start sample
        line_a = 1'b0;
        repeat (50) @(negedge clk_in);
        line_a = 1'b1;
        repeat (100) @(negedge clk_in);
        #1;
        checkOutput("glitch_no_valid", 32'(bus0.rx_valid), 32'h0);
        v = '{1'b0, 8'hFF, 1'b0, 1'b1, 40, 8'hFF, 1'b0, 1'b0, 1'b0};
        applyStimulus(v, 1'b1);

        // Reset pulse in the middle of data bit 4 of 0x81
        v = '{1'b0, 8'h81, 1'b0, 1'b1, 1000, 8'h81, 1'b0, 1'b0, 1'b0};
        fork
            applyStimulus(v, 1'b0);
            begin
                repeat (5 * BIT_CYC + BIT_CYC / 2) @(negedge clk_in);
                rst_in = 1'b1;
                @(negedge clk_in);
                rst_in = 1'b0;
                #1;
                checkOutput("midrst_valid", 32'(bus0.rx_valid), 32'h0);
                checkOutput("midrst_ferr", 32'(bus0.frame_err), 32'h0);
                checkOutput("midrst_data", 32'(bus0.rx_data), 32'h0);
                // The line is still low (data bits 4..6 are 0) when reset lifts, so the
                // receiver locks onto a phantom start and reads the tail as 0xFE.
                e = '{8'hFE, 1'b0, 1'b0, 1'b0, 0};
                q0.push_back(e);
            end
        join
        v = '{1'b0, 8'h42, 1'b0, 1'b1, 40, 8'h42, 1'b0, 1'b0, 1'b0};
        applyStimulus(v, 1'b1);

        waited = 0;
        while ((q0.size() != 0 || q2.size() != 0) && waited < 3000) begin
            @(negedge clk_in);
            waited++;
        end
        checks++;
        if (q0.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d pending required=0", q0.size() + q2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
